// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared types and helpers for the fifo_rr_arbiter block.
//               - arb_state_t : two-state arbiter encoding (IDLE / GRANT)
//               - chw(n)      : channel-index width, max(1, $clog2(n))
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int chw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arb_rr_pick
// Description : Combinational rotating-priority finder. Returns the first
//               requesting channel when scanning ptr, ptr+1, ... (mod NUM_CH).
// Ports       : req_i   [NUM_CH]  request vector (1 = channel has data)
//               ptr_i   [PW]      highest-priority channel this cycle
//               found_o           at least one request present
//               idx_o   [PW]      selected channel (0 when found_o = 0)
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_arb_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int PW     = chw(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [PW-1:0]     ptr_i,
    output logic              found_o,
    output logic [PW-1:0]     idx_o
);

    // Rotated distance of the best candidate found so far; NUM_CH means none.
    int w_best_dist;
    int w_dist;

    // Each channel's priority is its distance from ptr going upward with
    // wrap-around; the requester with the smallest distance wins. Iterating
    // over constant channel numbers keeps every vector index static.
    always_comb begin
        found_o     = 1'b0;
        idx_o       = '0;
        w_best_dist = NUM_CH;
        w_dist      = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (k >= int'(ptr_i)) begin
                w_dist = k - int'(ptr_i);
            end else begin
                w_dist = k + NUM_CH - int'(ptr_i);
            end
            if (req_i[k] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                found_o     = 1'b1;
                idx_o       = PW'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rr_arbiter
// Description : Round-robin read scheduler draining NUM_CH show-ahead FIFOs
//               into one registered valid/ready stream, in bursts of at most
//               MAX_BURST pops per grant.
// Ports       : clk_i    in   clock, rising edge
//               arst_i   in   asynchronous active-high reset
//               empty_i  in   [NUM_CH]        source FIFO empty flags
//               q_i      in   [NUM_CH*DWIDTH] show-ahead source data
//               rdreq_o  out  [NUM_CH]        pop strobe, one-hot or zero
//               data_o   out  [DWIDTH]        registered output word
//               ch_o     out  [chw(NUM_CH)]   source channel of data_o
//               valid_o  out                  data_o/ch_o valid
//               ready_i  in                   downstream accept
//               busy_o   out                  arbiter holds a grant
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DWIDTH    = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk_i,
    input  logic                       arst_i,
    input  logic [NUM_CH-1:0]          empty_i,
    input  logic [NUM_CH*DWIDTH-1:0]   q_i,
    output logic [NUM_CH-1:0]          rdreq_o,
    output logic [DWIDTH-1:0]          data_o,
    output logic [chw(NUM_CH)-1:0]     ch_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic                       busy_o
);

    localparam int CW = chw(NUM_CH);
    localparam int BW = $clog2(MAX_BURST + 1);

    localparam logic [CW-1:0] C_LAST_CH   = CW'(NUM_CH - 1);
    localparam logic [BW-1:0] C_LAST_BEAT = BW'(MAX_BURST - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_t          state_q,     state_d;
    logic [CW-1:0]       rr_ptr_q,    rr_ptr_d;
    logic [CW-1:0]       grant_q,     grant_d;
    logic [BW-1:0]       burst_cnt_q, burst_cnt_d;
    logic                valid_q,     valid_d;
    logic [DWIDTH-1:0]   data_q,      data_d;
    logic [CW-1:0]       ch_q,        ch_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                w_found;
    logic [CW-1:0]       w_pick;
    logic                w_gnt_empty;
    logic [DWIDTH-1:0]   w_gnt_data;
    logic                w_out_free;
    logic                w_pop;
    logic [CW-1:0]       w_next_ptr;

    fifo_arb_rr_pick #(
        .NUM_CH (NUM_CH),
        .PW     (CW)
    ) u_pick (
        .req_i   (~empty_i),
        .ptr_i   (rr_ptr_q),
        .found_o (w_found),
        .idx_o   (w_pick)
    );

    // Mux the granted channel's flag and data with a compare per channel so
    // that non-power-of-two channel counts never index past the vectors.
    always_comb begin
        w_gnt_empty = 1'b1;
        w_gnt_data  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant_q == CW'(k)) begin
                w_gnt_empty = empty_i[k];
                w_gnt_data  = q_i[k*DWIDTH +: DWIDTH];
            end
        end
    end

    // The output register can take a new word if empty or being drained.
    assign w_out_free = !valid_q || ready_i;
    assign w_pop      = (state_q == GRANT) && !w_gnt_empty && w_out_free;

    // Explicit wrap so non-power-of-two NUM_CH never lands on a hole.
    assign w_next_ptr = (grant_q == C_LAST_CH) ? '0 : grant_q + 1'b1;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        burst_cnt_d = burst_cnt_q;
        valid_d     = valid_q;
        data_d      = data_q;
        ch_d        = ch_q;

        // Output register: load on pop, otherwise drain on ready.
        if (w_pop) begin
            data_d  = w_gnt_data;
            ch_d    = grant_q;
            valid_d = 1'b1;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // The pick cycle issues no pop; that is the per-grant bubble.
                if (w_found) begin
                    grant_d     = w_pick;
                    burst_cnt_d = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (w_pop) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
                // Running dry releases the grant even while stalled.
                if ((w_pop && (burst_cnt_q == C_LAST_BEAT)) || w_gnt_empty) begin
                    state_d  = IDLE;
                    rr_ptr_d = w_next_ptr;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            burst_cnt_q <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            ch_q        <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            burst_cnt_q <= burst_cnt_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            ch_q        <= ch_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        rdreq_o = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            rdreq_o[k] = w_pop && (grant_q == CW'(k));
        end
    end

    assign busy_o  = (state_q == GRANT);
    assign data_o  = data_q;
    assign ch_o    = ch_q;
    assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rr_arbiter
// Description : Self-checking bench for fifo_rr_arbiter. Source FIFOs are
//               queues; a cycle reference model predicts rdreq/busy and the
//               registered output from the scheduling rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rr_arbiter;

    localparam int NUM_CH    = 4;
    localparam int DWIDTH    = 4;
    localparam int MAX_BURST = 4;

    logic                     clk_i = 1'b0;
    logic                     arst_i;
    logic [NUM_CH-1:0]        empty_i;
    logic [NUM_CH*DWIDTH-1:0] q_i;
    logic [NUM_CH-1:0]        rdreq_o;
    logic [DWIDTH-1:0]        data_o;
    logic [1:0]               ch_o;
    logic                     valid_o;
    logic                     ready_i;
    logic                     busy_o;

    fifo_rr_arbiter #(
        .NUM_CH    (NUM_CH),
        .DWIDTH    (DWIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .empty_i (empty_i),
        .q_i     (q_i),
        .rdreq_o (rdreq_o),
        .data_o  (data_o),
        .ch_o    (ch_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Source FIFO contents
    logic [DWIDTH-1:0] fq [NUM_CH][$];
    logic [DWIDTH-1:0] seq_val [NUM_CH];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model
    bit                m_busy;
    bit                m_valid;
    int                m_grant;
    int                m_cnt;
    int                m_ptr;
    logic [DWIDTH-1:0] m_data;
    int                m_ch;

    logic [NUM_CH-1:0] last_rdreq;
    logic [DWIDTH-1:0] acc_d[$];
    int                acc_c[$];
    int                acc_cyc[$];
    bit                rand_en;
    int                pulses;
    int                exp_ch[$];
    int                cnt_per_ch [NUM_CH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic update_inputs();
        for (int k = 0; k < NUM_CH; k++) begin
            empty_i[k] = (fq[k].size() == 0);
            q_i[k*DWIDTH +: DWIDTH] = (fq[k].size() == 0) ? '0 : fq[k][0];
        end
    endtask

    task automatic m_reset();
        m_busy  = 0;
        m_valid = 0;
        m_grant = 0;
        m_cnt   = 0;
        m_ptr   = 0;
        m_data  = '0;
        m_ch    = 0;
    endtask

    task automatic fill(input int ch, input int n, input int base);
        for (int i = 0; i < n; i++) fq[ch].push_back(DWIDTH'(base + i));
    endtask

    function automatic bit all_empty();
        for (int k = 0; k < NUM_CH; k++) if (fq[k].size() != 0) return 0;
        return 1;
    endfunction

    // One clock: check combinational outputs, advance the model, clock,
    // apply pops/pushes, then check the registered outputs.
    task automatic tick();
        bit                free;
        bit                gempty;
        bit                pop;
        logic [NUM_CH-1:0] exp_rd;
        #1;
        last_rdreq = rdreq_o;
        chk("no_pop_empty", 32'(rdreq_o & empty_i), 32'h0);
        if (valid_o && ready_i) begin
            acc_d.push_back(data_o);
            acc_c.push_back(int'(ch_o));
            acc_cyc.push_back(cyc);
        end
        exp_rd = '0;
        if (arst_i) begin
            m_reset();
        end else begin
            free = !m_valid || ready_i;
            if (!m_busy) begin
                if (ready_i) m_valid = 0;
                for (int i = NUM_CH - 1; i >= 0; i--) begin
                    if (fq[(m_ptr + i) % NUM_CH].size() > 0) begin
                        m_grant = (m_ptr + i) % NUM_CH;
                        m_busy  = 1;
                    end
                end
                m_cnt = 0;
            end else begin
                gempty = (fq[m_grant].size() == 0);
                pop    = !gempty && free;
                if (pop) begin
                    exp_rd[m_grant] = 1'b1;
                    m_data  = fq[m_grant][0];
                    m_ch    = m_grant;
                    m_valid = 1;
                    m_cnt++;
                end else if (ready_i) begin
                    m_valid = 0;
                end
                if ((pop && m_cnt == MAX_BURST) || gempty) begin
                    m_busy = 0;
                    m_ptr  = (m_grant + 1) % NUM_CH;
                end
            end
        end
        chk("rdreq_o", 32'(rdreq_o), 32'(exp_rd));
        @(posedge clk_i);
        #1;
        cyc++;
        for (int k = 0; k < NUM_CH; k++)
            if (last_rdreq[k] && fq[k].size() > 0) void'(fq[k].pop_front());
        if (rand_en) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if ($urandom_range(3) == 0 && fq[k].size() < 16) begin
                    fq[k].push_back(seq_val[k]);
                    seq_val[k] = seq_val[k] + 1'b1;
                end
            end
            ready_i = ($urandom_range(3) != 0);
        end
        update_inputs();
        chk("busy_o",  32'(busy_o),  32'(m_busy));
        chk("valid_o", 32'(valid_o), 32'(m_valid));
        chk("data_o",  32'(data_o),  32'(m_data));
        chk("ch_o",    32'(ch_o),    32'(m_ch));
    endtask

    task automatic do_reset();
        arst_i = 1'b1;
        for (int k = 0; k < NUM_CH; k++) fq[k].delete();
        update_inputs();
        m_reset();
        tick();
        tick();
        arst_i = 1'b0;
        acc_d.delete();
        acc_c.delete();
        acc_cyc.delete();
    endtask

    initial begin
        arst_i  = 1'b1;
        ready_i = 1'b1;
        rand_en = 0;
        for (int k = 0; k < NUM_CH; k++) seq_val[k] = '0;
        m_reset();

        // ---- Reset with every FIFO non-empty ----
        for (int k = 0; k < NUM_CH; k++) fill(k, 2, 0);
        update_inputs();
        repeat (3) tick();
        chk("reset_rdreq", 32'(rdreq_o), 32'h0);
        chk("reset_valid", 32'(valid_o), 32'h0);
        chk("reset_data",  32'(data_o),  32'h0);
        chk("reset_ch",    32'(ch_o),    32'h0);
        arst_i = 1'b0;
        tick();
        chk("first_cycle_no_pop", 32'(last_rdreq), 32'h0);
        tick();
        chk("first_pop_ch0", 32'(last_rdreq), 32'h1);
        for (int i = 0; i < 100 && !(all_empty() && !valid_o); i++) tick();
        chk("reset_drain_done", 32'(all_empty() && !valid_o), 32'h1);

        // ---- Burst limit: ch0 holds 0..9 ----
        do_reset();
        fill(0, 10, 0);
        update_inputs();
        repeat (30) tick();
        chk("burst_count", 32'(acc_d.size()), 32'd10);
        for (int i = 0; i < acc_d.size() && i < 10; i++) begin
            chk("burst_data", 32'(acc_d[i]), 32'(i));
            chk("burst_ch",   32'(acc_c[i]), 32'h0);
        end
        if (acc_cyc.size() >= 10) begin
            chk("burst_back2back", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
            chk("burst_gap1",      32'(acc_cyc[4] - acc_cyc[3]), 32'd2);
            chk("burst_gap2",      32'(acc_cyc[8] - acc_cyc[7]), 32'd2);
        end

        // ---- Round robin: 8 words on every channel ----
        do_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            fill(k, 8, 0);
            cnt_per_ch[k] = 0;
        end
        update_inputs();
        repeat (80) tick();
        exp_ch.delete();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NUM_CH; c++)
                repeat (MAX_BURST) exp_ch.push_back(c);
        chk("rr_count", 32'(acc_d.size()), 32'd32);
        for (int i = 0; i < acc_c.size() && i < 32; i++) begin
            chk("rr_ch", 32'(acc_c[i]), 32'(exp_ch[i]));
            chk("rr_order", 32'(acc_d[i]), 32'(cnt_per_ch[acc_c[i]]));
            cnt_per_ch[acc_c[i]]++;
        end

        // ---- Backpressure on ch2 ----
        do_reset();
        fill(2, 3, 5);
        update_inputs();
        ready_i = 1'b0;
        pulses  = 0;
        repeat (10) begin
            tick();
            if (last_rdreq != '0) pulses++;
        end
        chk("bp_one_pulse", 32'(pulses), 32'd1);
        chk("bp_data_held", 32'(data_o), 32'd5);
        chk("bp_valid_held", 32'(valid_o), 32'd1);
        chk("bp_ch", 32'(ch_o), 32'd2);
        ready_i = 1'b1;
        repeat (10) tick();
        chk("bp_count", 32'(acc_d.size()), 32'd3);
        for (int i = 0; i < acc_d.size() && i < 3; i++)
            chk("bp_data", 32'(acc_d[i]), 32'(5 + i));
        if (acc_cyc.size() == 3) begin
            chk("bp_no_bubble1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
            chk("bp_no_bubble2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd1);
        end

        // ---- Empty mid-burst: ch1 x2, ch3 x5 ----
        do_reset();
        fill(1, 2, 0);
        fill(3, 5, 8);
        update_inputs();
        repeat (30) tick();
        exp_ch.delete();
        exp_ch = '{1, 1, 3, 3, 3, 3, 3};
        chk("emb_count", 32'(acc_c.size()), 32'd7);
        for (int i = 0; i < acc_c.size() && i < 7; i++)
            chk("emb_ch", 32'(acc_c[i]), 32'(exp_ch[i]));

        // ---- Asynchronous reset mid-burst ----
        do_reset();
        fill(0, 6, 0);
        update_inputs();
        for (int i = 0; i < 10 && !valid_o; i++) tick();
        chk("pre_arst_valid", 32'(valid_o), 32'd1);
        #2;
        arst_i = 1'b1;
        #1;
        chk("arst_valid", 32'(valid_o), 32'd0);
        chk("arst_rdreq", 32'(rdreq_o), 32'd0);
        chk("arst_busy",  32'(busy_o),  32'd0);
        m_reset();
        for (int k = 1; k < NUM_CH; k++) fill(k, 2, 0);
        update_inputs();
        tick();
        tick();
        arst_i = 1'b0;
        tick();
        chk("restart_idle", 32'(last_rdreq), 32'h0);
        tick();
        chk("restart_ch0", 32'(last_rdreq), 32'h1);
        for (int i = 0; i < 200 && !(all_empty() && !valid_o); i++) tick();
        chk("arst_drain_done", 32'(all_empty() && !valid_o), 32'h1);

        // ---- Randomized traffic against the model ----
        do_reset();
        rand_en = 1;
        repeat (800) tick();
        rand_en = 0;
        ready_i = 1'b1;
        for (int i = 0; i < 300 && !(all_empty() && !valid_o); i++) tick();
        chk("rand_drain_done", 32'(all_empty() && !valid_o), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
